// File: rtl/wb_pkg.sv
// Shared constants and the writeback entry type for the register-file writeback arbiter.
package wb_pkg;

    localparam int REG_ZERO = 0;
    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic [WB_AW-1:0] regAddr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for secondary writebacks; entries are presented oldest-first so
// index 0 is always the head. clrn is an active-high synchronous clear.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         push,
    input  logic [AW-1:0]                pushReg,
    input  logic [DW-1:0]                pushData,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0][AW-1:0]     entryReg,
    output logic [DEPTH-1:0][DW-1:0]     entryData,
    output logic [DEPTH-1:0]             entryValid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] regMem  [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign doPush = push && (count < CW'(DEPTH));
    assign doPop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (clrn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: validity comes solely from the occupancy count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            regMem[wrPtr]  <= pushReg;
            dataMem[wrPtr] <= pushData;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entryReg[k]   = regMem[rdPtr + PW'(k)];
            entryData[k]  = dataMem[rdPtr + PW'(k)];
            entryValid[k] = CW'(k) < count;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (priority) and mult/div (FIFO-buffered) writebacks onto the register file
// write port and flags read hazards. Define WB_BYPASS_EN to add forwarding outputs.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         p_valid,
    input  logic [AW-1:0]                p_reg,
    input  logic [DW-1:0]                p_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [AW-1:0]                s_reg,
    input  logic [DW-1:0]                s_data,
    input  logic [AW-1:0]                q_regA,
    input  logic [AW-1:0]                q_regB,
    output logic                         hazardA,
    output logic                         hazardB,
    output logic                         ctrl_writeEnable,
    output logic [AW-1:0]                ctrl_writeReg,
    output logic [DW-1:0]                data_writeReg,
`ifdef WB_BYPASS_EN
    output logic                         fwdA_valid,
    output logic [DW-1:0]                fwdA_data,
    output logic                         fwdB_valid,
    output logic [DW-1:0]                fwdB_data,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic                     primarySel;
    logic                     fifoPush;
    logic                     fifoPop;
    logic [DEPTH-1:0][AW-1:0] entryReg;
    logic [DEPTH-1:0][DW-1:0] entryData;
    logic [DEPTH-1:0]         entryValid;
    logic                     rawHazardA;
    logic                     rawHazardB;

    assign primarySel = p_valid && (p_reg != AW'(REG_ZERO));
    assign s_ready    = !ctrl_reset && (fifo_count < CW'(DEPTH));
    assign fifoPush   = s_valid && s_ready && (s_reg != AW'(REG_ZERO));
    assign fifoPop    = !primarySel && entryValid[0];

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) fifo (
        .clk        (clock),
        .clrn       (ctrl_reset),
        .push       (fifoPush),
        .pushReg    (s_reg),
        .pushData   (s_data),
        .pop        (fifoPop),
        .count      (fifo_count),
        .entryReg   (entryReg),
        .entryData  (entryData),
        .entryValid (entryValid)
    );

    // Idle slots keep address/data so the register file sees a stable bus.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (primarySel) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= p_reg;
            data_writeReg    <= p_data;
        end else if (fifoPop) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= entryReg[0];
            data_writeReg    <= entryData[0];
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    always_comb begin
        rawHazardA = 1'b0;
        rawHazardB = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entryValid[k] && entryReg[k] == q_regA) rawHazardA = 1'b1;
            if (entryValid[k] && entryReg[k] == q_regB) rawHazardB = 1'b1;
        end
        if (ctrl_writeEnable && ctrl_writeReg == q_regA) rawHazardA = 1'b1;
        if (ctrl_writeEnable && ctrl_writeReg == q_regB) rawHazardB = 1'b1;
        if (q_regA == AW'(REG_ZERO)) rawHazardA = 1'b0;
        if (q_regB == AW'(REG_ZERO)) rawHazardB = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Output stage is oldest; later FIFO slots overwrite so the newest match wins.
    always_comb begin
        fwdA_valid = 1'b0;
        fwdA_data  = '0;
        fwdB_valid = 1'b0;
        fwdB_data  = '0;
        if (ctrl_writeEnable && ctrl_writeReg == q_regA) begin
            fwdA_valid = 1'b1;
            fwdA_data  = data_writeReg;
        end
        if (ctrl_writeEnable && ctrl_writeReg == q_regB) begin
            fwdB_valid = 1'b1;
            fwdB_data  = data_writeReg;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (entryValid[k] && entryReg[k] == q_regA) begin
                fwdA_valid = 1'b1;
                fwdA_data  = entryData[k];
            end
            if (entryValid[k] && entryReg[k] == q_regB) begin
                fwdB_valid = 1'b1;
                fwdB_data  = entryData[k];
            end
        end
        if (q_regA == AW'(REG_ZERO)) fwdA_valid = 1'b0;
        if (q_regB == AW'(REG_ZERO)) fwdB_valid = 1'b0;
    end

    assign hazardA = rawHazardA && !fwdA_valid;
    assign hazardB = rawHazardB && !fwdB_valid;
`else
    assign hazardA = rawHazardA;
    assign hazardB = rawHazardB;
`endif

endmodule
